// File: rtl/imem_loader.sv
// Host-side instruction memory loader: packs a valid/ready byte stream into
// little-endian SIZE-bit words and writes them while the CPU is held.
module imem_loader #(
  parameter int SIZE   = 64,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_index,
  input  logic [ADDR_W:0]   word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] imem_index,
  output logic [SIZE-1:0]   imem_data,
  output logic              imem_en,
  output logic              imem_wr,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [SIZE-1:0]   checksum
);

  localparam int BYTES = SIZE / 8;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

  state_t            state, state_nx;
  logic [BC_W-1:0]   byte_cnt, byte_cnt_nx;
  logic [SIZE-1:0]   word_buf, word_nx;
  logic [ADDR_W-1:0] index, index_nx;
  logic [ADDR_W:0]   remain, remain_nx;
  logic [SIZE-1:0]   chk_nx, imem_data_nx;
  logic [ADDR_W-1:0] imem_index_nx;
  logic              err_nx;

  always_comb begin
    state_nx      = state;
    byte_cnt_nx   = byte_cnt;
    word_nx       = word_buf;
    index_nx      = index;
    remain_nx     = remain;
    chk_nx        = checksum;
    imem_data_nx  = imem_data;
    imem_index_nx = imem_index;
    err_nx        = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (word_count == '0) begin
            chk_nx   = '0;
            state_nx = S_DONE;
          end else if (word_count > DEPTH_C) begin
            err_nx = 1'b1;
          end else begin
            index_nx    = base_index;
            remain_nx   = word_count;
            byte_cnt_nx = '0;
            chk_nx      = '0;
            state_nx    = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (in_valid && in_ready) begin
          for (int unsigned k = 0; k < BYTES; k++) begin
            if (byte_cnt == BC_W'(k)) word_nx[8*k +: 8] = in_data;
          end
          if (byte_cnt == LAST_BYTE) begin
            // Word goes straight to the output register so it is valid during WRITE.
            imem_data_nx  = word_nx;
            imem_index_nx = index;
            state_nx      = S_WRITE;
          end else begin
            byte_cnt_nx = byte_cnt + BC_W'(1);
          end
        end
      end
      S_WRITE: begin
        chk_nx    = checksum ^ imem_data;
        remain_nx = remain - (ADDR_W+1)'(1);
        if (remain == (ADDR_W+1)'(1)) begin
          state_nx = S_DONE;
        end else begin
          index_nx    = (index == LAST_IDX) ? '0 : index + ADDR_W'(1);
          byte_cnt_nx = '0;
          state_nx    = S_LOAD;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they are registered
  // yet line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      byte_cnt   <= '0;
      word_buf   <= '0;
      index      <= '0;
      remain     <= '0;
      checksum   <= '0;
      imem_data  <= '0;
      imem_index <= '0;
      imem_en    <= 1'b0;
      imem_wr    <= 1'b0;
      in_ready   <= 1'b0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      byte_cnt   <= byte_cnt_nx;
      word_buf   <= word_nx;
      index      <= index_nx;
      remain     <= remain_nx;
      checksum   <= chk_nx;
      imem_data  <= imem_data_nx;
      imem_index <= imem_index_nx;
      imem_en    <= (state_nx == S_WRITE);
      imem_wr    <= (state_nx == S_WRITE);
      in_ready   <= (state_nx == S_LOAD);
      cpu_hold   <= (state_nx == S_LOAD) || (state_nx == S_WRITE);
      busy       <= (state_nx == S_LOAD) || (state_nx == S_WRITE);
      done       <= (state_nx == S_DONE);
      err        <= err_nx;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed scoreboard bench for imem_loader: expected writes are queued as
// words are sent and checked when the write strobe appears.
module tb_imem_loader;
  localparam int SIZE   = 64;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_index;
  logic [ADDR_W:0]   word_count;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] imem_index;
  logic [SIZE-1:0]   imem_data;
  logic              imem_en;
  logic              imem_wr;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [SIZE-1:0]   checksum;

  imem_loader #(.SIZE(SIZE), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_index(base_index),
    .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_index(imem_index), .imem_data(imem_data),
    .imem_en(imem_en), .imem_wr(imem_wr), .cpu_hold(cpu_hold), .busy(busy),
    .done(done), .err(err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] idx;
    logic [SIZE-1:0]   data;
  } wr_t;

  wr_t sb_q[$];
  int  tests = 0;
  int  fails = 0;
  int  write_cnt = 0;
  int  acc_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (in_valid && in_ready) acc_cnt++;
      if (imem_en === 1'b1) begin
        write_cnt++;
        check("imem_wr", 64'(imem_wr), 64'd1);
        check("write_expected", 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
          wr_t e;
          e = sb_q.pop_front();
          check("imem_index", 64'(imem_index), 64'(e.idx));
          check("imem_data", imem_data, e.data);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] wc);
    base_index = b;
    word_count = wc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_wait", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [ADDR_W-1:0] idx, input logic [SIZE-1:0] w);
    wr_t e;
    e.idx  = idx;
    e.data = w;
    sb_q.push_back(e);
    for (int k = 0; k < SIZE / 8; k++) send_byte(w[8*k +: 8]);
  endtask

  initial begin
    logic [SIZE-1:0] wa, wb, wc2;
    int wcnt0, acc0;
    rst_n = 1'b0; start = 1'b0; base_index = '0; word_count = '0;
    in_valid = 1'b0; in_data = '0;

    // Reset, then idle
    repeat (3) tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_cpu_hold", 64'(cpu_hold), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_imem_en", 64'(imem_en), 64'd0);
    check("rst_checksum", checksum, 64'd0);
    check("rst_imem_data", imem_data, 64'd0);
    check("rst_imem_index", 64'(imem_index), 64'd0);
    rst_n = 1'b1;
    tick();
    in_valid = 1'b1; in_data = 8'h55;
    repeat (3) tick();
    in_valid = 1'b0;
    check("idle_in_ready", 64'(in_ready), 64'd0);
    check("idle_no_accept", 64'(acc_cnt), 64'd0);

    // Single word at index 5
    wa = 64'h0807060504030201;
    do_start(8'd5, 9'd1);
    check("sw_busy", 64'(busy), 64'd1);
    check("sw_cpu_hold", 64'(cpu_hold), 64'd1);
    send_word(8'd5, wa);
    check("sw_write_strobe", 64'(imem_en), 64'd1);
    check("sw_hold_in_write", 64'(cpu_hold), 64'd1);
    check("sw_ready_in_write", 64'(in_ready), 64'd0);
    tick();
    check("sw_done", 64'(done), 64'd1);
    check("sw_hold_off", 64'(cpu_hold), 64'd0);
    check("sw_checksum", checksum, wa);
    tick();
    check("sw_done_pulse", 64'(done), 64'd0);
    check("sw_writes", 64'(write_cnt), 64'd1);

    // Wrap 255 -> 0 with a 4-cycle stall mid-word
    wa = 64'h1817161514131211;
    wb = 64'hA8A7A6A5A4A3A2A1;
    acc0 = acc_cnt;
    do_start(8'd255, 9'd2);
    sb_q.push_back('{idx: 8'd255, data: wa});
    for (int k = 0; k < 3; k++) send_byte(wa[8*k +: 8]);
    repeat (4) tick();
    check("stall_ready", 64'(in_ready), 64'd1);
    check("stall_no_accept", 64'(acc_cnt - acc0), 64'd3);
    for (int k = 3; k < 8; k++) send_byte(wa[8*k +: 8]);
    send_word(8'd0, wb);
    tick();
    check("wrap_done", 64'(done), 64'd1);
    check("wrap_checksum", checksum, wa ^ wb);
    check("wrap_bytes", 64'(acc_cnt - acc0), 64'd16);
    check("wrap_writes", 64'(write_cnt), 64'd3);
    tick();

    // Rejection: zero count and oversize count
    do_start(8'd7, 9'd0);
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    check("zero_checksum", checksum, 64'd0);
    tick();
    do_start(8'd7, 9'd257);
    check("over_err", 64'(err), 64'd1);
    check("over_hold", 64'(cpu_hold), 64'd0);
    check("over_busy", 64'(busy), 64'd0);
    tick();
    check("over_err_pulse", 64'(err), 64'd0);
    check("over_idle", 64'(in_ready), 64'd0);
    check("reject_writes", 64'(write_cnt), 64'd3);

    // Reset during word 2 of 3
    wa = 64'h0123456789ABCDEF;
    wb = 64'hFEDCBA9876543210;
    do_start(8'd10, 9'd3);
    send_word(8'd10, wa);
    for (int k = 0; k < 5; k++) send_byte(wb[8*k +: 8]);
    wcnt0 = write_cnt;
    rst_n = 1'b0;
    #1;
    check("mid_rst_hold", 64'(cpu_hold), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("mid_rst_writes", 64'(write_cnt - wcnt0), 64'd0);
    wc2 = 64'h1122334455667788;
    do_start(8'd20, 9'd1);
    send_word(8'd20, wc2);
    tick();
    check("after_rst_done", 64'(done), 64'd1);
    check("after_rst_checksum", checksum, wc2);
    tick();

    // Start during LOAD is ignored
    wa = 64'hCAFEBABE00C0FFEE;
    wb = 64'h5A5A5A5AA5A5A5A5;
    do_start(8'd40, 9'd2);
    sb_q.push_back('{idx: 8'd40, data: wa});
    send_byte(wa[7:0]);
    base_index = 8'd99; word_count = 9'd5; start = 1'b1;
    send_byte(wa[15:8]);
    start = 1'b0;
    check("ign_err", 64'(err), 64'd0);
    for (int k = 2; k < 8; k++) send_byte(wa[8*k +: 8]);
    send_word(8'd41, wb);
    tick();
    check("ign_done", 64'(done), 64'd1);
    check("ign_checksum", checksum, wa ^ wb);
    tick();
    check("ign_idle", 64'(busy), 64'd0);

    repeat (3) tick();
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
